// File: rtl/router_pkt_source_if.sv
// Bundle of host-request, payload-stream and router-port signals for router_pkt_source.
// master = the packet source itself, slave = the host/router environment.
interface router_pkt_source_if;
  logic       tx_start;
  logic [1:0] tx_dest;
  logic [5:0] tx_len;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       tx_done;
  logic       tx_reject;
`ifdef ERR_INJECT_EN
  logic       inject_err;

  modport master (
    input  tx_start, tx_dest, tx_len, src_data, src_valid, busy, inject_err,
    output src_ready, pkt_valid, data_out, tx_active, tx_done, tx_reject
  );

  modport slave (
    output tx_start, tx_dest, tx_len, src_data, src_valid, busy, inject_err,
    input  src_ready, pkt_valid, data_out, tx_active, tx_done, tx_reject
  );
`else
  modport master (
    input  tx_start, tx_dest, tx_len, src_data, src_valid, busy,
    output src_ready, pkt_valid, data_out, tx_active, tx_done, tx_reject
  );

  modport slave (
    output tx_start, tx_dest, tx_len, src_data, src_valid, busy,
    input  src_ready, pkt_valid, data_out, tx_active, tx_done, tx_reject
  );
`endif
endinterface

// File: rtl/router_pkt_source.sv
// Packet source for a router input port: buffers len payload bytes, then emits header, payload, parity.
// Optional ERR_INJECT_EN adds bus.inject_err, which inverts bit 0 of the parity byte of that packet.
module router_pkt_source #(
  parameter int MAX_LEN = 63
) (
  input  logic                clock,
  input  logic                resetn,
  router_pkt_source_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4
  } state_t;

  // The 6-bit len field caps the buffer at 63 bytes regardless of the parameter.
  localparam logic [5:0] LEN_LIMIT = (MAX_LEN > 63) ? 6'd63 : 6'(MAX_LEN);

  state_t     state_q, state_d;
  logic [1:0] dest_q, dest_d;
  logic [5:0] len_q, len_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] parity_q, parity_d;
  logic [7:0] data_q, data_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       active_q;
  logic       inj_q, inj_d;
  logic       mem_we;
  logic       start_legal;
  logic       start_inj;
  logic [7:0] mem [64];

  assign start_legal = (bus.tx_dest != 2'd3) && (bus.tx_len != 6'd0) && (bus.tx_len <= LEN_LIMIT);

`ifdef ERR_INJECT_EN
  assign start_inj = bus.inject_err;
`else
  assign start_inj = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    parity_d    = parity_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    reject_d    = 1'b0;
    inj_d       = inj_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        data_d      = 8'h00;
        pkt_valid_d = 1'b0;
        if (bus.tx_start) begin
          if (start_legal) begin
            dest_d   = bus.tx_dest;
            len_d    = bus.tx_len;
            parity_d = {bus.tx_len, bus.tx_dest};
            wr_cnt_d = 6'd0;
            inj_d    = start_inj;
            state_d  = COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.src_valid) begin
          mem_we   = 1'b1;
          parity_d = parity_q ^ bus.src_data;
          wr_cnt_d = wr_cnt_q + 6'd1;
          // Header goes out right after the last byte lands, so pkt_valid never gaps.
          if (wr_cnt_q == len_q - 6'd1) begin
            data_d      = {len_q, dest_q};
            pkt_valid_d = 1'b1;
            state_d     = HEADER;
          end
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          data_d   = mem[6'd0];
          rd_cnt_d = 6'd1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          if (rd_cnt_q == len_q) begin
            data_d      = parity_q ^ {7'd0, inj_q};
            pkt_valid_d = 1'b0;
            state_d     = PARITY;
          end else begin
            data_d   = mem[rd_cnt_q];
            rd_cnt_d = rd_cnt_q + 6'd1;
          end
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          data_d  = 8'h00;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      dest_q      <= 2'd0;
      len_q       <= 6'd0;
      wr_cnt_q    <= 6'd0;
      rd_cnt_q    <= 6'd0;
      parity_q    <= 8'h00;
      data_q      <= 8'h00;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
      active_q    <= 1'b0;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      parity_q    <= parity_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
      active_q    <= (state_d != IDLE);
      inj_q       <= inj_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_cnt_q] <= bus.src_data;
    end
  end

  assign bus.src_ready = (state_q == COLLECT);
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.data_out  = data_q;
  assign bus.tx_active = active_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_reject = reject_q;

endmodule
